// File: rtl/dpi_mem_arb_pkg.sv
// Shared types and defaults for the simulation memory-port arbiter.
package dpi_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HALT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: bit 0 = fetch, bit 1 = load/store.
// With both requesters valid, the one that did not win last time is granted.
module mem_arb_rr2
  import dpi_mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  owner_e     last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant selection
  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == OWN_LS) ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/dpi_mem_arbiter.sv
// Shares the single simulation memory port between instruction fetch and
// load/store, with a fixed access latency and deferred simulation halt.
// Optional macro DPI_MEM_ARB_PERF_EN adds saturating grant/conflict counters.
module dpi_mem_arbiter
  import dpi_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                halt_req,
  output logic                halt
`ifdef DPI_MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_ls_grants,
  output logic [31:0]         perf_conflict_cycles
`endif
);

  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned MASK_W = DATA_W / 8;

  if (LATENCY < 1) begin : g_latency_check
    $error("dpi_mem_arbiter: LATENCY must be at least 1");
  end

  state_e              state_q, state_d;
  owner_e              last_q, last_d;
  owner_e              owner_q, owner_d;
  logic                hpend_q, hpend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                halt_q;
  logic [1:0]          grant;
  logic                arb_en;

  mem_arb_rr2 u_rr2 (
    .valid_i      ({ls_req_valid, if_req_valid}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  // Arbitration is only open in IDLE with no halt requested or pending;
  // ready is also held low while reset is asserted so every output reads 0.
  assign arb_en       = (state_q == IDLE) && !halt_req && !hpend_q && !rst;
  assign if_req_ready = arb_en && grant[0];
  assign ls_req_ready = arb_en && grant[1];

  // Next-state, handshake capture and latency countdown
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    hpend_d = hpend_q | halt_req;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (halt_req || hpend_q) begin
          state_d = HALT;
        end else if (if_req_ready) begin
          state_d = WAIT;
          owner_d = OWN_IF;
          last_d  = OWN_IF;
          addr_d  = if_req_addr;
          wen_d   = 1'b0;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else if (ls_req_ready) begin
          state_d = WAIT;
          owner_d = OWN_LS;
          last_d  = OWN_LS;
          addr_d  = ls_req_addr;
          wen_d   = ls_req_wen;
          wdata_d = ls_req_wdata;
          wmask_d = ls_req_wmask;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!wen_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = hpend_q ? HALT : IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWN_LS;
      owner_q <= OWN_IF;
      hpend_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      hpend_q <= hpend_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      halt_q  <= (state_d == HALT);
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign mem_wen       = (state_q == WAIT) && (cnt_q == '0) && wen_q;
  assign if_resp_valid = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_resp_valid = (state_q == RESP) && (owner_q == OWN_LS);
  assign if_resp_data  = if_resp_valid ? rdata_q : '0;
  assign ls_resp_data  = (ls_resp_valid && !wen_q) ? rdata_q : '0;
  assign halt          = halt_q;

`ifdef DPI_MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_ls_q, perf_conf_q;

  // Saturating grant and conflict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q   <= '0;
      perf_ls_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (if_req_ready && perf_if_q != '1) perf_if_q <= perf_if_q + 1'b1;
      if (ls_req_ready && perf_ls_q != '1) perf_ls_q <= perf_ls_q + 1'b1;
      if (arb_en && if_req_valid && ls_req_valid && perf_conf_q != '1)
        perf_conf_q <= perf_conf_q + 1'b1;
    end
  end

  assign perf_if_grants       = perf_if_q;
  assign perf_ls_grants       = perf_ls_q;
  assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule
